// File: rtl/clk_lock_mon_pkg.sv
// clk_lock_mon shared types: FSM state encoding, loss counter width
// and the unsigned tolerance-window check.
package clk_lock_mon_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        MEASURE   = 2'd2,
        RUN       = 2'd3
    } state_e;

    localparam int LOSS_W = 8;

    // Lower bound clamps at zero when the tolerance exceeds the target
    function automatic logic in_tol(
        input int unsigned cnt,
        input int unsigned exp_v,
        input int unsigned tol
    );
        int unsigned lo;
        lo = (exp_v > tol) ? exp_v - tol : 0;
        return (cnt >= lo) && (cnt <= exp_v + tol);
    endfunction

endpackage

// File: rtl/clk_lock_mon_sync_2ff.sv
// sync_2ff: two-flop synchroniser for one asynchronous level,
// async active-low reset.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/clk_lock_mon.sv
// clk_lock_mon: DCM lock / ADC_ENC frequency supervisor and ADC reset
// sequencer. Define CLK_LOCK_MON_FREQ_CHECK_EN to enable frequency windows.
module clk_lock_mon
    import clk_lock_mon_pkg::*;
#(
    parameter int LOCK_WAIT = 1024,
    parameter int WINDOW    = 4800,
    parameter int ENC_EXP   = 1000,
    parameter int ENC_TOL   = 4,
    parameter int CNT_W     = 16
) (
    input  logic             BUS_CLK,
    input  logic             BUS_RST_N,
    input  logic             LOCKED,
    input  logic             ADC_ENC,
    input  logic             CLR_CNT,
    output logic             RST_OUT,
    output logic             CLK_OK,
    output logic             FREQ_OK,
    output logic [CNT_W-1:0] ENC_FREQ,
    output logic [LOSS_W-1:0] LOSS_CNT,
    output logic [1:0]       STATE
);

    localparam int SW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

    logic lock_s;
    logic enc_s;

    sync_2ff u_sync_lock (
        .clk_i  (BUS_CLK),
        .rst_ni (BUS_RST_N),
        .d_i    (LOCKED),
        .q_o    (lock_s)
    );

    sync_2ff u_sync_enc (
        .clk_i  (BUS_CLK),
        .rst_ni (BUS_RST_N),
        .d_i    (ADC_ENC),
        .q_o    (enc_s)
    );

    state_e            state_q, state_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic [LOSS_W-1:0] loss_q, loss_d;
    logic              rst_q, ok_q;
    logic              loss_inc;
    logic              settle_end;
    logic              win_ok;
    logic              win_bad;

    assign settle_end = (settle_q == SW'(LOCK_WAIT - 1));

`ifdef CLK_LOCK_MON_FREQ_CHECK_EN
    localparam state_e SETTLE_NEXT = MEASURE;
    localparam int     WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    logic             enc_d_q;
    logic [WW-1:0]    win_q, win_d;
    logic [CNT_W-1:0] edge_q, edge_d;
    logic [CNT_W-1:0] freq_q, freq_d;
    logic [CNT_W-1:0] cnt_now;
    logic             fok_q, fok_d;
    logic             rise, in_win, win_end, good;

    assign rise    = enc_s & ~enc_d_q;
    assign in_win  = (state_q == MEASURE) || (state_q == RUN);
    assign win_end = in_win && (win_q == WW'(WINDOW - 1));
    // Count including this cycle's edge, so a closing-cycle edge is kept
    assign cnt_now = (rise && (edge_q != '1)) ? edge_q + 1'b1 : edge_q;
    assign good    = in_tol(32'(cnt_now), ENC_EXP, ENC_TOL);
    assign win_ok  = win_end && good;
    assign win_bad = win_end && !good;

    always_comb begin
        win_d  = '0;
        edge_d = '0;
        freq_d = freq_q;
        fok_d  = fok_q;
        if (in_win && lock_s) begin
            if (win_end) begin
                freq_d = cnt_now;
                fok_d  = good;
            end else begin
                win_d  = win_q + 1'b1;
                edge_d = cnt_now;
            end
        end
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            enc_d_q <= 1'b0;
            win_q   <= '0;
            edge_q  <= '0;
            freq_q  <= '0;
            fok_q   <= 1'b0;
        end else begin
            enc_d_q <= enc_s;
            win_q   <= win_d;
            edge_q  <= edge_d;
            freq_q  <= freq_d;
            fok_q   <= fok_d;
        end
    end

    assign ENC_FREQ = freq_q;
    assign FREQ_OK  = fok_q;
`else
    localparam state_e SETTLE_NEXT = RUN;

    logic unused_cfg;

    assign unused_cfg = ^{enc_s, 32'(WINDOW), 32'(ENC_EXP), 32'(ENC_TOL)};
    assign win_ok     = 1'b0;
    assign win_bad    = 1'b0;
    assign ENC_FREQ   = '0;
    assign FREQ_OK    = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        settle_d = '0;
        loss_inc = 1'b0;
        unique case (state_q)
            WAIT_LOCK: begin
                if (lock_s) state_d = SETTLE;
            end
            SETTLE: begin
                if (!lock_s)         state_d = WAIT_LOCK;
                else if (settle_end) state_d = SETTLE_NEXT;
                else                 settle_d = settle_q + 1'b1;
            end
            MEASURE: begin
                if (!lock_s)     state_d = WAIT_LOCK;
                else if (win_ok) state_d = RUN;
            end
            RUN: begin
                if (!lock_s || win_bad) begin
                    state_d  = WAIT_LOCK;
                    loss_inc = 1'b1;
                end
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    always_comb begin
        loss_d = loss_q;
        if (CLR_CNT) begin
            loss_d = loss_inc ? LOSS_W'(1) : '0;
        end else if (loss_inc && (loss_q != '1)) begin
            loss_d = loss_q + 1'b1;
        end
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            state_q  <= WAIT_LOCK;
            settle_q <= '0;
            loss_q   <= '0;
            rst_q    <= 1'b1;
            ok_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            loss_q   <= loss_d;
            rst_q    <= (state_d != RUN);
            ok_q     <= (state_d == RUN);
        end
    end

    assign RST_OUT  = rst_q;
    assign CLK_OK   = ok_q;
    assign LOSS_CNT = loss_q;
    assign STATE    = state_q;

endmodule

// File: tb/tb_clk_lock_mon.sv
// tb_clk_lock_mon: directed bench for clk_lock_mon with shortened
// settle/window parameters; follows CLK_LOCK_MON_FREQ_CHECK_EN.
module tb_clk_lock_mon;

    localparam int LW  = 16;
    localparam int WIN = 60;

`ifdef CLK_LOCK_MON_FREQ_CHECK_EN
    localparam int T_REL   = 3 + LW + WIN;
    localparam int PRE_RUN = 2;
    localparam int ENC_RUN = 12;
    localparam int FOK_RST = 0;
`else
    localparam int T_REL   = 3 + LW;
    localparam int PRE_RUN = 1;
    localparam int ENC_RUN = 0;
    localparam int FOK_RST = 1;
`endif

    logic       BUS_CLK;
    logic       BUS_RST_N;
    logic       LOCKED;
    logic       ADC_ENC;
    logic       CLR_CNT;
    logic       RST_OUT;
    logic       CLK_OK;
    logic       FREQ_OK;
    logic [7:0] ENC_FREQ;
    logic [7:0] LOSS_CNT;
    logic [1:0] STATE;

    int n_cmp = 0;
    int n_bad = 0;
    int enc_per;
    int ph;
    int eloss;

    clk_lock_mon #(
        .LOCK_WAIT (LW),
        .WINDOW    (WIN),
        .ENC_EXP   (12),
        .ENC_TOL   (2),
        .CNT_W     (8)
    ) dut (
        .BUS_CLK   (BUS_CLK),
        .BUS_RST_N (BUS_RST_N),
        .LOCKED    (LOCKED),
        .ADC_ENC   (ADC_ENC),
        .CLR_CNT   (CLR_CNT),
        .RST_OUT   (RST_OUT),
        .CLK_OK    (CLK_OK),
        .FREQ_OK   (FREQ_OK),
        .ENC_FREQ  (ENC_FREQ),
        .LOSS_CNT  (LOSS_CNT),
        .STATE     (STATE)
    );

    initial BUS_CLK = 1'b0;
    always #5 BUS_CLK = ~BUS_CLK;

    // One rising ADC_ENC edge every enc_per cycles
    initial begin
        ADC_ENC = 1'b0;
        ph = 0;
        forever begin
            @(posedge BUS_CLK);
            #2;
            if (enc_per < 2) begin
                ADC_ENC = 1'b0;
            end else begin
                if (ph >= enc_per - 1) ph = 0;
                else ph = ph + 1;
                ADC_ENC = (ph < enc_per / 2);
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "timeout");
    end

    task automatic step(input int n);
        repeat (n) @(posedge BUS_CLK);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp_v);
        end
    endtask

    task automatic chk_all(
        input string tag,
        input int st, input int rst, input int ok,
        input int loss, input int enc, input int fok
    );
        chk({tag, "_state"}, STATE, st);
        chk({tag, "_rst"}, RST_OUT, rst);
        chk({tag, "_clkok"}, CLK_OK, ok);
        chk({tag, "_loss"}, LOSS_CNT, loss);
        chk({tag, "_encf"}, ENC_FREQ, enc);
        chk({tag, "_fok"}, FREQ_OK, fok);
    endtask

    typedef struct {
        int   n;
        logic lk;
        logic clr;
        int   st;
        int   rst;
        int   ok;
        int   loss;
        int   enc;
        int   fok;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{1, 1'b0, 1'b0, 0, 1, 0, 0, 0, FOK_RST};
        tbl[1] = '{2, 1'b1, 1'b0, 0, 1, 0, 0, 0, FOK_RST};
        tbl[2] = '{1, 1'b1, 1'b0, 1, 1, 0, 0, 0, FOK_RST};
        tbl[3] = '{T_REL - 4, 1'b1, 1'b0, PRE_RUN, 1, 0, 0, 0, FOK_RST};
        tbl[4] = '{1, 1'b1, 1'b0, 3, 0, 1, 0, ENC_RUN, 1};
        tbl[5] = '{2, 1'b0, 1'b0, 3, 0, 1, 0, ENC_RUN, 1};
        tbl[6] = '{1, 1'b0, 1'b0, 0, 1, 0, 1, ENC_RUN, 1};
        tbl[7] = '{1, 1'b0, 1'b1, 0, 1, 0, 0, ENC_RUN, 1};
        tbl[8] = '{1, 1'b0, 1'b0, 0, 1, 0, 0, ENC_RUN, 1};

        BUS_RST_N = 1'b0;
        LOCKED    = 1'b0;
        CLR_CNT   = 1'b0;
        enc_per   = 5;
        eloss     = 0;
        step(3);
        BUS_RST_N = 1'b1;

        for (int i = 0; i < 9; i++) begin
            LOCKED  = tbl[i].lk;
            CLR_CNT = tbl[i].clr;
            step(tbl[i].n);
            chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].rst,
                    tbl[i].ok, tbl[i].loss, tbl[i].enc, tbl[i].fok);
        end

        // Lock glitch of 5 cycles at settle count 8
        LOCKED = 1'b1;
        step(11);
        chk("glitch_settle", STATE, 1);
        LOCKED = 1'b0;
        step(3);
        chk("glitch_wait", STATE, 0);
        step(2);
        LOCKED = 1'b1;
        step(T_REL - 1);
        chk("glitch_pre_state", STATE, PRE_RUN);
        chk("glitch_pre_rst", RST_OUT, 1);
        step(1);
        chk("glitch_run", STATE, 3);
        chk("glitch_loss", LOSS_CNT, 0);
        LOCKED = 1'b0;
        step(3);
        eloss = 1;
        chk("drop_rst", RST_OUT, 1);
        chk("drop_loss", LOSS_CNT, eloss);

`ifdef CLK_LOCK_MON_FREQ_CHECK_EN
        // 15 edges/window is above the 10..14 band
        enc_per = 4;
        LOCKED  = 1'b1;
        step(T_REL);
        chk("meas_state", STATE, 2);
        chk("meas_rst", RST_OUT, 1);
        chk("meas_encf", ENC_FREQ, 15);
        chk("meas_fok", FREQ_OK, 0);
        enc_per = 6;
        step(120);
        chk("tol_state", STATE, 3);
        chk("tol_encf", ENC_FREQ, 10);
        chk("tol_fok", FREQ_OK, 1);
        step(60);
        chk("win_encf", ENC_FREQ, 10);
        // Lock loss lands on the next window end; result must be dropped
        step(5);
        enc_per = 4;
        step(52);
        LOCKED = 1'b0;
        step(2);
        chk("coin_pre", STATE, 3);
        step(1);
        eloss++;
        chk("coin_state", STATE, 0);
        chk("coin_rst", RST_OUT, 1);
        chk("coin_encf", ENC_FREQ, 10);
        chk("coin_fok", FREQ_OK, 1);
        chk("coin_loss", LOSS_CNT, eloss);
        enc_per = 5;
`endif

        for (int i = 0; i < 260; i++) begin
            LOCKED = 1'b1;
            step(T_REL);
            chk($sformatf("sat_run%0d", i), STATE, 3);
            LOCKED = 1'b0;
            step(3);
        end
        chk("sat_loss", LOSS_CNT, 255);

        LOCKED = 1'b1;
        step(T_REL);
        LOCKED = 1'b0;
        step(2);
        CLR_CNT = 1'b1;
        step(1);
        CLR_CNT = 1'b0;
        chk("clr_inc_state", STATE, 0);
        chk("clr_inc_loss", LOSS_CNT, 1);

        // Async reset mid-window while running
        LOCKED = 1'b1;
        step(T_REL);
        chk("ar_run", STATE, 3);
        step(20);
        #3;
        BUS_RST_N = 1'b0;
        #1;
        chk_all("ar_now", 0, 1, 0, 0, 0, FOK_RST);
        step(1);
        BUS_RST_N = 1'b1;
        step(T_REL - 1);
        chk("ar_pre", STATE, PRE_RUN);
        chk("ar_pre_rst", RST_OUT, 1);
        step(1);
        chk_all("ar_rel", 3, 0, 1, 0, ENC_RUN, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clk_lock_mon.md
# clk_lock_mon

Clock-health monitor and reset sequencer that sits directly downstream of the DCM clock generator. It runs on BUS_CLK and watches the DCM `LOCKED` flag and the 10 MHz ADC encode clock. It holds the ADC readout logic in reset until lock has been stable for a programmable time and the measured ADC_ENC frequency is in tolerance. After release it keeps supervising both, and re-asserts reset on any fault.

## Interface
Parameters:
- `LOCK_WAIT`, 1024: BUS_CLK cycles of continuous lock required before measuring.
- `WINDOW`, 4800: BUS_CLK cycles per frequency window (100 µs at 48 MHz).
- `ENC_EXP`, 1000: expected ADC_ENC rising edges per window.
- `ENC_TOL`, 4: allowed ± deviation from `ENC_EXP`.
- `CNT_W`, 16: width of the edge counter and of `ENC_FREQ`.

Ports:
- `BUS_CLK` in 1: 48 MHz system clock; the only clock.
- `BUS_RST_N` in 1: asynchronous, active-low reset.
- `LOCKED` in 1: DCM lock flag, asynchronous to BUS_CLK.
- `ADC_ENC` in 1: 10 MHz encode clock, sampled as asynchronous data.
- `CLR_CNT` in 1: single-cycle pulse; clears `LOSS_CNT`.
- `RST_OUT` out 1: synchronous active-high reset for the ADC path.
- `CLK_OK` out 1: high only while in the RUN state.
- `FREQ_OK` out 1: result of the last completed window.
- `ENC_FREQ` out CNT_W: edge count latched from the last completed window.
- `LOSS_CNT` out 8: saturating count of RUN→fault exits.
- `STATE` out 2: current state encoding.

## Operation
Input synchronisation:
- `LOCKED` passes through a 2-FF synchroniser to give `lock_s`.
- `ADC_ENC` passes through a 2-FF synchroniser plus a third FF. A rising edge is `enc_s & ~enc_d`.

State machine (`STATE` encoding in brackets):
- WAIT_LOCK (0): `RST_OUT`=1. Move to SETTLE when `lock_s`=1.
- SETTLE (1): settle counter runs from 0 to LOCK_WAIT-1. At the terminal count, move to MEASURE. If `lock_s`=0, return to WAIT_LOCK and clear the counter.
- MEASURE (2): counts windows while `RST_OUT` stays at 1.
  - In-tolerance window → RUN.
  - Out-of-tolerance window → start a fresh window and stay in MEASURE.
  - `lock_s`=0 → WAIT_LOCK.
- RUN (3): `RST_OUT`=0, `CLK_OK`=1, windows continue.
  - Out-of-tolerance window or `lock_s`=0 → WAIT_LOCK, and `LOSS_CNT` increments.

Frequency window:
- The window counter runs 0..WINDOW-1 in MEASURE and RUN only. It is cleared in every other state.
- The edge counter saturates at 2^CNT_W-1.
- An edge detected in cycle WINDOW-1 belongs to the window that is closing.
- At window end:
  - `ENC_FREQ` ← count (including that edge).
  - `FREQ_OK` ← (ENC_EXP-ENC_TOL ≤ count ≤ ENC_EXP+ENC_TOL). The comparison is unsigned; if ENC_EXP < ENC_TOL, the lower bound is clamped to 0.
  - The edge counter restarts at 0, or at 1 if an edge coincides with the restart cycle.
- Lock loss takes priority over a window end in the same cycle. The window result is discarded and `ENC_FREQ`/`FREQ_OK` hold their values.

LOSS_CNT:
- Saturates at 255.
- `CLR_CNT` together with an increment in the same cycle gives 1.

## Timing
- Reset values: `RST_OUT`=1, `CLK_OK`=0, `FREQ_OK`=0, `ENC_FREQ`=0, `LOSS_CNT`=0, `STATE`=0. All internal counters are 0.
- Asserting `BUS_RST_N` at any point, including mid-window, forces the reset values immediately.
- Latency from `LOCKED` to `lock_s`: 2 cycles.
- Release: `RST_OUT` falls and `CLK_OK` rises in the same cycle, 1 cycle after the closing cycle of the first good window. With defaults this is 2+1024+4800+1 = 5827 cycles after `LOCKED` rises, provided ADC_ENC is in tolerance.
- Fault: `RST_OUT` rises and `CLK_OK` falls 1 cycle after the fault is detected. For lock loss this is 3 cycles after `LOCKED` falls.
- All outputs are registered. No combinational input-to-output paths.

## Configuration
- Macro: `CLK_LOCK_MON_FREQ_CHECK_EN`.
- Defined: frequency windowing works as described above.
- Undefined: the window and edge logic is removed.
  - SETTLE goes straight to RUN at its terminal count. MEASURE is unreachable.
  - `ENC_FREQ`=0 and `FREQ_OK`=1 constantly.
  - Lock loss is the only fault source.

## Structure
- Package `clk_lock_mon_pkg`:
  - state enum/localparams (WAIT_LOCK=0, SETTLE=1, MEASURE=2, RUN=3);
  - `LOSS_CNT` width constant (8).
- Sub-module `sync_2ff`: generic 2-FF synchroniser with async active-low reset. It is instantiated for `LOCKED` and `ADC_ENC`.
- The FSM, counters and comparison live in the top module.

## Test plan
- **Good lock and clock.** Defaults; `LOCKED` rises at cycle 100; ADC_ENC runs at exactly 48/4.8.
  - `RST_OUT` falls at cycle 5927.
  - `ENC_FREQ` = 1000, `FREQ_OK` = 1, `STATE` = 3.
- **Lock glitch in SETTLE.** `LOCKED` drops for 5 cycles at settle count 500.
  - Return to WAIT_LOCK; the full 1024-cycle settle restarts.
  - `LOSS_CNT` stays 0.
- **Off-frequency in MEASURE.** ADC_ENC gives 990 edges/window.
  - Stays in MEASURE with `FREQ_OK` = 0, `ENC_FREQ` = 990, `RST_OUT` = 1.
  - Switching to 1003 edges/window → RUN after the next window.
- **Lock loss in RUN coinciding with a window end.**
  - `RST_OUT` rises 3 cycles after `LOCKED` falls.
  - `LOSS_CNT` = 1; `ENC_FREQ` keeps its previous value.
- **LOSS_CNT saturation and clear.** Force 260 RUN faults.
  - `LOSS_CNT` = 255.
  - `CLR_CNT` in the same cycle as a fault → `LOSS_CNT` = 1.
- **Async reset mid-window in RUN.** Assert `BUS_RST_N`.
  - All outputs take their reset values in the same cycle.
  - After release, the sequence repeats the first scenario.
